// File: rtl/seg_display_queue_pkg.sv
// Shared types and constants for the queued seven-segment display bank.
// Outputs are active-low: a set bit is an unlit segment.
package seg_display_pkg;

  localparam logic [31:0] SEG_BLANK = '1;

  typedef enum logic {
    IDLE,
    HOLD
  } hold_state_e;

  // Default-geometry update record (6 channels of 7-bit patterns)
  typedef struct packed {
    logic [2:0] chan;
    logic [6:0] data;
  } seg_update_t;

  // Active-low gfedcba encodings for hex digits
  function automatic logic [6:0] segDigit(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0: pattern = 7'h40;
      4'h1: pattern = 7'h79;
      4'h2: pattern = 7'h24;
      4'h3: pattern = 7'h30;
      4'h4: pattern = 7'h19;
      4'h5: pattern = 7'h12;
      4'h6: pattern = 7'h02;
      4'h7: pattern = 7'h78;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h10;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h03;
      4'hC: pattern = 7'h46;
      4'hD: pattern = 7'h21;
      4'hE: pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg_display_queue_fifo.sv
// Small synchronous FIFO of an arbitrary packed type.
// DEPTH must be a power of two so the pointers wrap on natural overflow.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  T                             wdata_i,
  output T                             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            doPush, doPop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o && !clear_i;
  assign doPop  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    if (doPush && !doPop)      count_d = count_q + CNTW'(1);
    else if (!doPush && doPop) count_d = count_q - CNTW'(1);
  end

  // Storage carries no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seg_display_queue.sv
// Multi-channel display register bank fed by a FIFO; commits are spaced
// at least HOLD_CYCLES apart so each pattern stays visible.
module seg_display_queue
  import seg_display_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int CHANNELS    = 6,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(CHANNELS)-1:0]   in_chan,
  input  logic [WIDTH-1:0]              in_data,
  output logic [CHANNELS*WIDTH-1:0]     out,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          busy
);

  localparam int CW = $clog2(CHANNELS);
  localparam int TW = $clog2(HOLD_CYCLES+1);
  localparam logic [CHANNELS*WIDTH-1:0] ALL_BLANK = {CHANNELS{SEG_BLANK[WIDTH-1:0]}};

  typedef struct packed {
    logic [CW-1:0]    chan;
    logic [WIDTH-1:0] data;
  } update_t;

  update_t                   pushEntry, headEntry;
  logic                      fifoFull, fifoEmpty, pushEn, commit;
  hold_state_e               state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [CHANNELS*WIDTH-1:0] out_q, out_d;

  // A pop in the same cycle does not free a slot for the producer
  assign in_ready  = !fifoFull && !flush;
  assign pushEn    = in_valid && in_ready;
  assign pushEntry = '{chan: in_chan, data: in_data};

  sync_fifo #(
    .T     (update_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .push_i  (pushEn),
    .pop_i   (commit),
    .wdata_i (pushEntry),
    .rdata_o (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    out_d   = out_q;
    commit  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      timer_d = '0;
      out_d   = ALL_BLANK;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifoEmpty) begin
            commit  = 1'b1;
            timer_d = TW'(HOLD_CYCLES - 1);
            state_d = (HOLD_CYCLES > 1) ? HOLD : IDLE;
            // Out-of-range channels match nothing but still consume a hold slot
            for (int c = 0; c < CHANNELS; c++) begin
              if (headEntry.chan == CW'(c)) out_d[c*WIDTH +: WIDTH] = headEntry.data;
            end
          end
        end
        HOLD: begin
          timer_d = timer_q - TW'(1);
          if (timer_q == TW'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      out_q   <= ALL_BLANK;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign busy = !fifoEmpty || (state_q == HOLD);

endmodule

// File: tb/tb_seg_display_queue.sv
// Self-checking bench for seg_display_queue: vector table, corner-case
// sequences, and random traffic against a queue-based reference model.
module tb_seg_display_queue;

  localparam int WIDTH    = 7;
  localparam int CHANNELS = 6;
  localparam int DEPTH    = 4;
  localparam int HOLD     = 5;
  localparam int OW       = CHANNELS * WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, inValid, inReady, busy;
  logic [2:0]    inChan, count;
  logic [6:0]    inData;
  logic [OW-1:0] outBus;

  logic          reset1, flush1, inValid1, inReady1, busy1;
  logic [2:0]    inChan1, count1;
  logic [6:0]    inData1;
  logic [OW-1:0] outBus1;

  seg_display_queue #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(inReady),
    .in_chan(inChan), .in_data(inData), .out(outBus), .count(count), .busy(busy)
  );

  seg_display_queue #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1), .flush(flush1), .in_valid(inValid1), .in_ready(inReady1),
    .in_chan(inChan1), .in_data(inData1), .out(outBus1), .count(count1), .busy(busy1)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: display contents, pending updates, cycles left in hold
  typedef struct { int chan; int data; } entry_t;
  entry_t mQ[$];
  int     mSeg[CHANNELS];
  int     mHold;

  typedef struct {
    logic r, f, v;
    logic [2:0] ch;
    logic [6:0] d;
    logic [OW-1:0] eOut;
    int eCount;
    logic eBusy, eReady;
  } vec_t;

  function automatic logic [OW-1:0] modelOut();
    logic [OW-1:0] o;
    o = '1;
    for (int c = 0; c < CHANNELS; c++) o[c*WIDTH +: WIDTH] = 7'(mSeg[c]);
    return o;
  endfunction

  function automatic logic [OW-1:0] withChan(input logic [OW-1:0] base, input int c, input logic [6:0] d);
    logic [OW-1:0] o;
    o = base;
    o[c*WIDTH +: WIDTH] = d;
    return o;
  endfunction

  task automatic modelClear();
    mQ.delete();
    for (int c = 0; c < CHANNELS; c++) mSeg[c] = 'h7F;
    mHold = 0;
  endtask

  task automatic modelStep();
    bit accept;
    entry_t e;
    if (reset || flush) begin
      modelClear();
    end else begin
      accept = inValid && (mQ.size() < DEPTH);
      if (mQ.size() > 0 && mHold == 0) begin
        e = mQ.pop_front();
        if (e.chan < CHANNELS) mSeg[e.chan] = e.data;
        mHold = HOLD - 1;
      end else if (mHold > 0) begin
        mHold--;
      end
      if (accept) mQ.push_back('{int'(inChan), int'(inData)});
    end
  endtask

  task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " out"}, 64'(outBus), 64'(modelOut()));
    checkValue({tag, " count"}, 64'(count), 64'(mQ.size()));
    checkValue({tag, " busy"}, 64'(busy), 64'((mQ.size() > 0) || (mHold > 0)));
    checkValue({tag, " in_ready"}, 64'(inReady), 64'((mQ.size() < DEPTH) && !flush));
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic [2:0] ch, input logic [6:0] d);
    reset   = r;
    flush   = f;
    inValid = v;
    inChan  = ch;
    inData  = d;
    #1;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  vec_t          vecs[10];
  logic [OW-1:0] blank, o2, expFinal, preOut;
  int            commitEdges[$];
  int            expEdges[6];
  int            acceptF, idx, busyCycles;
  bit            accepted;

  initial begin
    reset = 1'b1; flush = 1'b0; inValid = 1'b0; inChan = '0; inData = '0;
    reset1 = 1'b1; flush1 = 1'b0; inValid1 = 1'b0; inChan1 = '0; inData1 = '0;
    modelClear();
    blank = '1;
    o2    = withChan(blank, 2, 7'h40);

    // Basic path: reset, single update latency, hold countdown, flush dropping a push
    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 7'h00, blank, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 3'd2, 7'h40, blank, 1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 7'h00, o2,    0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 7'h00, o2,    0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd0, 7'h00, o2,    0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 3'd0, 7'h00, o2,    0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd0, 7'h00, o2,    0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 3'd5, 7'h12, o2,    1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 3'd0, 7'h33, blank, 0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 3'd0, 7'h00, blank, 0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].ch, vecs[i].d);
      tick();
      checkValue($sformatf("vec%0d out", i), 64'(outBus), 64'(vecs[i].eOut));
      checkValue($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].eCount));
      checkValue($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].eBusy));
      checkValue($sformatf("vec%0d in_ready", i), 64'(inReady), 64'(vecs[i].eReady));
    end

    // Back-to-back pushes: commit spacing, full back-pressure, order preserved
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 7'h00);
    tick();
    expEdges = '{1, 6, 11, 16, 21, 26};
    commitEdges.delete();
    acceptF = -1;
    idx = 0;
    for (int e = 0; e < 30; e++) begin
      if (idx < 6) applyStimulus(1'b0, 1'b0, 1'b1, 3'(idx), 7'(idx + 1));
      else         applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 7'h00);
      accepted = inValid && inReady;
      preOut   = outBus;
      tick();
      checkOutput($sformatf("order e%0d", e));
      if (accepted) begin
        if (idx == 5) acceptF = e;
        idx++;
      end
      if (outBus !== preOut) commitEdges.push_back(e);
    end
    checkValue("commit count", 64'(commitEdges.size()), 64'(6));
    for (int i = 0; i < 6 && i < commitEdges.size(); i++)
      checkValue($sformatf("commit edge %0d", i), 64'(commitEdges[i]), 64'(expEdges[i]));
    checkValue("waiting push accept edge", 64'(acceptF), 64'(7));
    expFinal = '1;
    for (int c = 0; c < CHANNELS; c++) expFinal[c*WIDTH +: WIDTH] = 7'(c + 1);
    checkValue("order final out", 64'(outBus), 64'(expFinal));

    // Flush with three entries queued mid-hold and a push presented alongside
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 7'h00);
    tick();
    for (int e = 0; e < 8; e++) begin
      if (e < 5) applyStimulus(1'b0, 1'b0, 1'b1, 3'(e), 7'(8'h11 + e));
      else       applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 7'h00);
      tick();
      checkOutput($sformatf("preflush e%0d", e));
    end
    checkValue("preflush count", 64'(count), 64'(3));
    checkValue("preflush busy", 64'(busy), 64'(1));
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd5, 7'h2A);
    tick();
    checkValue("flush count", 64'(count), 64'(0));
    checkValue("flush out", 64'(outBus), 64'(blank));
    checkValue("flush busy", 64'(busy), 64'(0));
    checkValue("flush in_ready", 64'(inReady), 64'(0));
    for (int e = 0; e < 8; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 7'h00);
      tick();
      checkOutput($sformatf("postflush e%0d", e));
    end
    checkValue("dropped push absent", 64'(outBus), 64'(blank));

    // Out-of-range channel still occupies a full hold window
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 7'h00);
    tick();
    busyCycles = 0;
    for (int e = 0; e < 8; e++) begin
      if (e == 0) applyStimulus(1'b0, 1'b0, 1'b1, 3'd7, 7'h00);
      else        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 7'h00);
      tick();
      checkOutput($sformatf("badchan e%0d", e));
      if (busy) busyCycles++;
    end
    checkValue("badchan busy cycles", 64'(busyCycles), 64'(5));
    checkValue("badchan out", 64'(outBus), 64'(blank));

    // Reset while holding one pattern and queueing another
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 7'h55);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 7'h66);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 7'h00);
    tick();
    checkValue("midhold out", 64'(outBus), 64'(withChan(blank, 1, 7'h55)));
    checkValue("midhold count", 64'(count), 64'(1));
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 7'h00);
    tick();
    checkValue("reset out", 64'(outBus), 64'(blank));
    checkValue("reset count", 64'(count), 64'(0));
    checkValue("reset busy", 64'(busy), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 7'h00);
    tick();
    checkValue("after reset out", 64'(outBus), 64'(blank));
    checkValue("after reset busy", 64'(busy), 64'(0));

    // Random traffic against the model
    for (int e = 0; e < 400; e++) begin
      applyStimulus(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom));
      tick();
      checkOutput($sformatf("rand%0d", e));
    end

    // HOLD_CYCLES = 1 instance: one commit per cycle, last same-channel value wins
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 7'h00);
    tick();
    reset1 = 1'b0;
    inValid1 = 1'b1; inChan1 = 3'd3; inData1 = 7'h11;
    tick();
    checkValue("h1 first count", 64'(count1), 64'(1));
    checkValue("h1 first out", 64'(outBus1), 64'(blank));
    checkValue("h1 first busy", 64'(busy1), 64'(1));
    inData1 = 7'h22;
    tick();
    checkValue("h1 commit 11", 64'(outBus1), 64'(withChan(blank, 3, 7'h11)));
    checkValue("h1 count a", 64'(count1), 64'(1));
    inData1 = 7'h33;
    tick();
    checkValue("h1 commit 22", 64'(outBus1), 64'(withChan(blank, 3, 7'h22)));
    inData1 = 7'h44;
    tick();
    checkValue("h1 commit 33", 64'(outBus1), 64'(withChan(blank, 3, 7'h33)));
    checkValue("h1 count b", 64'(count1), 64'(1));
    inValid1 = 1'b0;
    tick();
    checkValue("h1 last wins", 64'(outBus1), 64'(withChan(blank, 3, 7'h44)));
    checkValue("h1 final count", 64'(count1), 64'(0));
    checkValue("h1 final busy", 64'(busy1), 64'(0));
    checkValue("h1 in_ready", 64'(inReady1), 64'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
